// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game-flow sequencer.
package game_flow_pkg;

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSE,
        ST_DEAD,
        ST_OVER,
        ST_REPORT,
        ST_CREDITS
    } flow_state_t;

    // Non-level screens sit directly above the last level index.
    localparam int SEL_DEAD_OFS    = 1;
    localparam int SEL_REPORT_OFS  = 2;
    localparam int SEL_CREDITS_OFS = 3;
    localparam int SEL_PAUSE_OFS   = 4;

    function automatic int sel_width(input int num_levels);
        return $clog2(num_levels + SEL_PAUSE_OFS + 1);
    endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector whose history only advances on frame ticks, so a level
// held across many frames produces exactly one pulse.
module tick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= 1'b0;
        else if (tick)
            prev <= level;
    end

    assign rise = tick & level & ~prev;

endmodule

// File: rtl/game_flow_seq.sv
// Game-flow sequencer: title / level / death / report flow for NUM_LEVELS levels
// with pause, lives budget and saturating death counter; advances on frame_tick.
module game_flow_seq
    import game_flow_pkg::*;
#(
    parameter int  NUM_LEVELS = 2,
    parameter int  MAX_LIVES  = 3,
    parameter int  BGM_W      = 2,
    parameter int  CNT_W      = 8,
    localparam int SEL_W      = sel_width(NUM_LEVELS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_tick,
    input  logic                  soft_reset,
    input  logic                  confirm,
    input  logic [3:0]            selected,
    input  logic                  death,
    input  logic                  level_done,
    input  logic                  saved,
    input  logic                  restart,
    input  logic                  esc,
    input  logic                  pause_req,
    input  logic                  finish,
    output logic [SEL_W-1:0]      stage_sel,
    output logic [NUM_LEVELS-1:0] lvl_reset,
    output logic [BGM_W-1:0]      bgm,
    output logic [3:0]            record,
    output logic [3:0]            lives,
    output logic [CNT_W-1:0]      deaths,
    output logic                  frame_en
);

    localparam logic [3:0]            LAST_LVL   = 4'(NUM_LEVELS);
    localparam logic [3:0]            CRED_PICK  = 4'(NUM_LEVELS + 1);
    localparam logic [3:0]            LIVES_INIT = 4'(MAX_LIVES);
    localparam logic [NUM_LEVELS-1:0] ALL_RST    = '1;

    flow_state_t           state, state_n;
    logic [3:0]            cur, cur_n, record_n, lives_n;
    logic [CNT_W-1:0]      deaths_n;
    logic [SEL_W-1:0]      sel_n;
    logic [NUM_LEVELS-1:0] lrst_n;
    logic [BGM_W-1:0]      bgm_n;
    logic                  fen_n;
    logic                  pause_rise;
    logic                  pick_ok;

    tick_edge u_pause_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .tick  (frame_tick),
        .level (pause_req),
        .rise  (pause_rise)
    );

    // Level 1 is always open; later levels unlock once checkpointed.
    assign pick_ok = (selected != 4'd0) && (selected <= LAST_LVL) &&
                     ((selected == 4'd1) || (selected <= record));

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        record_n = record;
        lives_n  = lives;
        deaths_n = deaths;
        if (soft_reset) begin
            state_n  = ST_TITLE;
            cur_n    = 4'd1;
            record_n = '0;
        end else begin
            case (state)
                ST_TITLE: if (confirm) begin
                    if (pick_ok) begin
                        state_n = ST_LOAD;
                        cur_n   = selected;
                    end else if (selected == CRED_PICK) begin
                        state_n = ST_CREDITS;
                    end
                end
                ST_LOAD: state_n = ST_PLAY;
                ST_PLAY: begin
                    if (saved && (cur > record))
                        record_n = cur;
                    if (death) begin
                        if (deaths != '1)
                            deaths_n = deaths + CNT_W'(1);
                        if (MAX_LIVES != 0)
                            lives_n = lives - 4'd1;
                        state_n = (MAX_LIVES != 0 && lives == 4'd1) ? ST_OVER : ST_DEAD;
                    end else if (level_done) begin
                        if (cur < LAST_LVL) begin
                            cur_n   = cur + 4'd1;
                            state_n = ST_LOAD;
                        end else begin
                            state_n = ST_REPORT;
                        end
                    end else if (esc) begin
                        state_n = ST_TITLE;
                    end else if (pause_rise) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (esc)
                        state_n = ST_TITLE;
                    else if (pause_rise)
                        state_n = ST_PLAY;
                end
                ST_DEAD: if (restart) begin
                    state_n = ST_LOAD;
                    if (record != 4'd0)
                        cur_n = record;
                end
                ST_OVER: if (restart) begin
                    state_n  = ST_TITLE;
                    record_n = '0;
                end
                ST_REPORT:  if (finish) state_n = ST_TITLE;
                ST_CREDITS: if (restart || esc) state_n = ST_TITLE;
                default:    state_n = ST_TITLE;
            endcase
        end
        if (state_n == ST_TITLE)
            lives_n = LIVES_INIT;
    end

    // Screen outputs are decoded from the next state so they register alongside it.
    always_comb begin
        sel_n  = '0;
        lrst_n = ALL_RST;
        bgm_n  = '0;
        fen_n  = 1'b1;
        case (state_n)
            ST_LOAD: begin
                sel_n = SEL_W'(cur_n);
                bgm_n = BGM_W'(cur_n);
            end
            ST_PLAY: begin
                sel_n  = SEL_W'(cur_n);
                bgm_n  = BGM_W'(cur_n);
                lrst_n = ALL_RST & ~(NUM_LEVELS'(1) << (cur_n - 4'd1));
            end
            ST_PAUSE: begin
                sel_n  = SEL_W'(NUM_LEVELS + SEL_PAUSE_OFS);
                bgm_n  = BGM_W'(cur_n);
                lrst_n = ALL_RST & ~(NUM_LEVELS'(1) << (cur_n - 4'd1));
                fen_n  = 1'b0;
            end
            ST_DEAD, ST_OVER: begin
                sel_n = SEL_W'(NUM_LEVELS + SEL_DEAD_OFS);
                bgm_n = '1;
            end
            ST_REPORT:  sel_n = SEL_W'(NUM_LEVELS + SEL_REPORT_OFS);
            ST_CREDITS: sel_n = SEL_W'(NUM_LEVELS + SEL_CREDITS_OFS);
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_TITLE;
            cur       <= 4'd1;
            record    <= '0;
            lives     <= LIVES_INIT;
            deaths    <= '0;
            stage_sel <= '0;
            lvl_reset <= '1;
            bgm       <= '0;
            frame_en  <= 1'b1;
        end else if (frame_tick) begin
            state     <= state_n;
            cur       <= cur_n;
            record    <= record_n;
            lives     <= lives_n;
            deaths    <= deaths_n;
            stage_sel <= sel_n;
            lvl_reset <= lrst_n;
            bgm       <= bgm_n;
            frame_en  <= fen_n;
        end
    end

endmodule

// File: tb/tb_game_flow_seq.sv
// Bench for game_flow_seq: directed flows plus randomized frames checked against
// a screen-level reference model every clock.
module tb_game_flow_seq;

    localparam int NL = 2, ML = 3, BW = 2, CW = 8;
    localparam int SW = $clog2(NL + 5);
    localparam int M_TITLE = 0, M_LOAD = 1, M_PLAY = 2, M_PAUSE = 3,
                   M_DEAD = 4, M_OVER = 5, M_REPORT = 6, M_CREDITS = 7;

    logic          Clk = 1'b0, Reset_n = 1'b1, frame_tick = 1'b0;
    logic          soft_reset = 1'b0, confirm = 1'b0, death = 1'b0, level_done = 1'b0;
    logic          saved = 1'b0, restart = 1'b0, esc = 1'b0, pause_req = 1'b0, finish = 1'b0;
    logic [3:0]    selected = 4'd0;
    logic [SW-1:0] stage_sel;
    logic [NL-1:0] lvl_reset;
    logic [BW-1:0] bgm;
    logic [3:0]    record, lives;
    logic [CW-1:0] deaths;
    logic          frame_en;

    int checks = 0, failures = 0;
    int m_mode, m_cur, m_rec, m_lives, m_deaths;
    bit m_prev;

    game_flow_seq #(.NUM_LEVELS(NL), .MAX_LIVES(ML), .BGM_W(BW), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .soft_reset(soft_reset),
        .confirm(confirm), .selected(selected), .death(death), .level_done(level_done),
        .saved(saved), .restart(restart), .esc(esc), .pause_req(pause_req), .finish(finish),
        .stage_sel(stage_sel), .lvl_reset(lvl_reset), .bgm(bgm), .record(record),
        .lives(lives), .deaths(deaths), .frame_en(frame_en)
    );

    always #5 Clk = ~Clk;

    function automatic int e_sel();
        case (m_mode)
            M_LOAD, M_PLAY: return m_cur;
            M_PAUSE:        return NL + 4;
            M_DEAD, M_OVER: return NL + 1;
            M_REPORT:       return NL + 2;
            M_CREDITS:      return NL + 3;
            default:        return 0;
        endcase
    endfunction

    function automatic int e_lrst();
        int all = (1 << NL) - 1;
        if (m_mode == M_PLAY || m_mode == M_PAUSE) return all - (1 << (m_cur - 1));
        return all;
    endfunction

    function automatic int e_bgm();
        if (m_mode == M_LOAD || m_mode == M_PLAY || m_mode == M_PAUSE) return m_cur % (1 << BW);
        if (m_mode == M_DEAD || m_mode == M_OVER) return (1 << BW) - 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_TITLE; m_cur = 1; m_rec = 0; m_lives = ML; m_deaths = 0; m_prev = 1'b0;
    endtask

    task automatic model_tick();
        bit pe;
        int k;
        pe = pause_req && !m_prev;
        m_prev = pause_req;
        k = int'(selected);
        if (soft_reset) begin
            m_mode = M_TITLE; m_cur = 1; m_rec = 0;
        end else begin
            case (m_mode)
                M_TITLE: if (confirm) begin
                    if (k >= 1 && k <= NL && (k == 1 || k <= m_rec)) begin
                        m_cur = k; m_mode = M_LOAD;
                    end else if (k == NL + 1) m_mode = M_CREDITS;
                end
                M_LOAD: m_mode = M_PLAY;
                M_PLAY: begin
                    if (saved && m_cur > m_rec) m_rec = m_cur;
                    if (death) begin
                        if (m_deaths < (1 << CW) - 1) m_deaths++;
                        m_mode = (m_lives == 1) ? M_OVER : M_DEAD;
                        m_lives--;
                    end else if (level_done) begin
                        if (m_cur < NL) begin m_cur++; m_mode = M_LOAD; end
                        else m_mode = M_REPORT;
                    end else if (esc) m_mode = M_TITLE;
                    else if (pe) m_mode = M_PAUSE;
                end
                M_PAUSE: if (esc) m_mode = M_TITLE; else if (pe) m_mode = M_PLAY;
                M_DEAD: if (restart) begin
                    m_mode = M_LOAD;
                    if (m_rec != 0) m_cur = m_rec;
                end
                M_OVER: if (restart) begin m_mode = M_TITLE; m_rec = 0; end
                M_REPORT: if (finish) m_mode = M_TITLE;
                M_CREDITS: if (restart || esc) m_mode = M_TITLE;
                default: m_mode = M_TITLE;
            endcase
        end
        if (m_mode == M_TITLE) m_lives = ML;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("stage_sel", int'(stage_sel), e_sel());
        check("lvl_reset", int'(lvl_reset), e_lrst());
        check("bgm",       int'(bgm),       e_bgm());
        check("record",    int'(record),    m_rec);
        check("lives",     int'(lives),     m_lives);
        check("deaths",    int'(deaths),    m_deaths);
        check("frame_en",  int'(frame_en),  (m_mode == M_PAUSE) ? 0 : 1);
    endtask

    task automatic cycle(input bit tick);
        frame_tick = tick;
        @(posedge Clk);
        if (tick) model_tick();
        #1;
        compare_all();
    endtask

    // One off-tick cycle with junk inputs (must be ignored), then the tick with the real ones.
    task automatic frame();
        logic [12:0] keep;
        keep = {soft_reset, confirm, selected, death, level_done, saved, restart, esc, pause_req, finish};
        {soft_reset, confirm, selected, death, level_done, saved, restart, esc, pause_req, finish} = 13'($urandom);
        cycle(1'b0);
        {soft_reset, confirm, selected, death, level_done, saved, restart, esc, pause_req, finish} = keep;
        cycle(1'b1);
    endtask

    task automatic clr();
        {soft_reset, confirm, death, level_done, saved, restart, esc, finish} = '0;
        selected = 4'd0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("rst_sel", int'(stage_sel), 0);
        check("rst_lrst", int'(lvl_reset), 3);
        check("rst_lives", int'(lives), 3);
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        clr(); frame(); frame();
        check("idle_sel", int'(stage_sel), 0);
        check("idle_lrst", int'(lvl_reset), 3);

        clr(); confirm = 1'b1; selected = 4'd1; frame();
        check("load1_sel", int'(stage_sel), 1);
        check("load1_lrst", int'(lvl_reset), 3);
        clr(); frame();
        check("play1_lrst", int'(lvl_reset), 2);
        check("play1_bgm", int'(bgm), 1);
        clr(); level_done = 1'b1; frame(); clr(); frame();
        check("play2_lrst", int'(lvl_reset), 1);
        clr(); level_done = 1'b1; frame();
        check("report_sel", int'(stage_sel), 4);
        clr(); finish = 1'b1; frame();
        check("finish_sel", int'(stage_sel), 0);

        clr(); confirm = 1'b1; selected = 4'd1; frame(); clr(); frame();
        clr(); level_done = 1'b1; frame(); clr(); frame();
        clr(); saved = 1'b1; frame();
        clr(); death = 1'b1; frame();
        check("dead_rec", int'(record), 2);
        check("dead_sel", int'(stage_sel), 3);
        check("dead_lives", int'(lives), 2);
        check("dead_deaths", int'(deaths), 1);
        clr(); restart = 1'b1; frame(); clr(); frame();
        check("respawn_sel", int'(stage_sel), 2);
        clr(); death = 1'b1; frame(); clr(); restart = 1'b1; frame(); clr(); frame();
        clr(); death = 1'b1; frame();
        check("over_lives", int'(lives), 0);
        check("over_sel", int'(stage_sel), 3);
        clr(); restart = 1'b1; frame();
        check("over_title", int'(stage_sel), 0);
        check("over_rec", int'(record), 0);

        clr(); confirm = 1'b1; selected = 4'd1; frame(); clr(); frame();
        clr(); death = 1'b1; level_done = 1'b1; frame();
        check("prio_sel", int'(stage_sel), 3);
        clr(); restart = 1'b1; frame();
        check("prio_cur", int'(stage_sel), 1);
        clr(); frame();

        clr(); pause_req = 1'b1;
        repeat (5) frame();
        check("pause_fen", int'(frame_en), 0);
        check("pause_sel", int'(stage_sel), 6);
        death = 1'b1; frame();
        check("pause_death", int'(stage_sel), 6);
        clr(); pause_req = 1'b0; frame(); pause_req = 1'b1; frame();
        check("resume_fen", int'(frame_en), 1);
        check("resume_sel", int'(stage_sel), 1);
        clr(); pause_req = 1'b0; esc = 1'b1; frame();

        clr(); confirm = 1'b1; selected = 4'd2; frame();
        check("locked_sel", int'(stage_sel), 0);
        clr(); confirm = 1'b1; selected = 4'd3; frame();
        check("credits_sel", int'(stage_sel), 5);
        clr(); esc = 1'b1; frame();

        for (int i = 0; i < 600; i++) begin
            soft_reset = ($urandom_range(0, 49) == 0);
            confirm    = 1'($urandom_range(0, 1));
            selected   = 4'($urandom_range(0, 5));
            death      = ($urandom_range(0, 7) == 0);
            level_done = ($urandom_range(0, 5) == 0);
            saved      = ($urandom_range(0, 2) == 0);
            restart    = 1'($urandom_range(0, 1));
            esc        = ($urandom_range(0, 15) == 0);
            finish     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pause_req = ~pause_req;
            frame();
        end

        clr(); pause_req = 1'b0; soft_reset = 1'b1; frame();
        begin
            int extra = 0;
            for (int i = 0; i < 3000 && extra < 10; i++) begin
                clr();
                case (m_mode)
                    M_TITLE: begin confirm = 1'b1; selected = 4'd1; end
                    M_PLAY:  begin death = 1'b1; if (m_deaths == 255) extra++; end
                    default: restart = 1'b1;
                endcase
                frame();
            end
        end
        check("deaths_sat", int'(deaths), 255);

        clr(); soft_reset = 1'b1; frame();
        clr(); confirm = 1'b1; selected = 4'd1; frame(); clr(); frame();
        clr(); soft_reset = 1'b1; frame();
        check("soft_sel", int'(stage_sel), 0);
        check("soft_lrst", int'(lvl_reset), 3);
        check("soft_deaths", int'(deaths), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_seq.md
Name: game_flow_seq

Overview:
- Parametrised game-flow sequencer for the top level; replaces the hard-coded title/level/dead/report enum with an N-level generalisation.
- Receives frame-rate events from the stage blocks and the keyboard decode. Drives the stage select, one-hot per-level reset pulses, BGM track index and checkpoint record.
- Adds features the current flow lacks: pause, a lives budget with game-over, and a saturating death counter.
- Runs on the system clock; all state advances only on the frame tick pulse.

Parameters:
- NUM_LEVELS, 2, number of playable levels (1..14).
- MAX_LIVES, 3, deaths allowed before game over; 0 means unlimited.
- BGM_W, 2, width of the BGM track index.
- CNT_W, 8, width of the death counter.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame (synchronised new_frame edge).
- soft_reset  in  1  synchronous return-to-title; sampled on frame_tick.
- confirm  in  1  title-menu confirm.
- selected  in  4  title-menu choice: 1..NUM_LEVELS selects a level; NUM_LEVELS+1 selects credits.
- death  in  1  OR of level death flags.
- level_done  in  1  current level reached its exit.
- saved  in  1  checkpoint reached in the current level.
- restart  in  1  R key or switch.
- esc  in  1  abort to title.
- pause_req  in  1  pause toggle, level-sensitive; an internal edge detect operates on frame ticks.
- finish  in  1  report screen acknowledged.
- stage_sel  out  SEL_W  screen index; SEL_W = $clog2(NUM_LEVELS+5).
- lvl_reset  out  NUM_LEVELS  per-level reset; bit i holds level i+1 in reset.
- bgm  out  BGM_W  track index.
- record  out  4  highest checkpointed level; 0 = none.
- lives  out  4  remaining lives.
- deaths  out  CNT_W  total deaths, saturating.
- frame_en  out  1  low while paused; gates level physics.

Behaviour:
- stage_sel encoding:
  - 0 = title
  - 1..NUM_LEVELS = levels
  - NUM_LEVELS+1 = dead
  - NUM_LEVELS+2 = report
  - NUM_LEVELS+3 = credits
  - NUM_LEVELS+4 = paused overlay
- Reset (async assert, sync release), all outputs registered:
  - state TITLE, stage_sel 0, lvl_reset all-ones, bgm 0, record 0, lives MAX_LIVES, deaths 0, frame_en 1.
- Updates occur only on Clk edges where frame_tick=1. Outputs therefore change one frame after the causing event, and are held otherwise.
- soft_reset on a tick overrides everything: forces the reset values above, except the deaths counter.
- States: TITLE, LOAD, PLAY, PAUSE, DEAD, OVER, REPORT, CREDITS. cur (4b) holds the active level.
- TITLE:
  - lvl_reset all-ones, bgm 0, lives reloaded to MAX_LIVES.
  - On confirm with selected=k, 1<=k<=NUM_LEVELS: go to LOAD with cur=k if k==1 or k<=record; otherwise ignore.
  - On confirm with selected=NUM_LEVELS+1: go to CREDITS.
  - Any other selected value is ignored.
- LOAD: exactly one tick. lvl_reset all-ones, stage_sel=cur. Then go to PLAY.
- PLAY:
  - lvl_reset = all-ones except bit cur-1; bgm = cur mod 2^BGM_W; stage_sel=cur.
  - Priority death > level_done > esc > pause edge.
  - death: deaths+=1 (saturating at all-ones). lives-=1 if MAX_LIVES!=0. Go to OVER if lives was 1, else DEAD.
  - level_done: cur<NUM_LEVELS → cur+1, go to LOAD. cur==NUM_LEVELS → REPORT.
  - esc → TITLE.
  - saved (any tick in PLAY) → record = max(record, cur).
- PAUSE:
  - frame_en=0, stage_sel=NUM_LEVELS+4, lvl_reset unchanged from PLAY.
  - Pause edge → PLAY. esc → TITLE.
  - death and level_done are ignored.
- DEAD:
  - stage_sel=NUM_LEVELS+1, bgm all-ones, lvl_reset all-ones.
  - restart → LOAD with cur = record if record!=0, else cur unchanged.
- OVER:
  - Same outputs as DEAD.
  - restart → TITLE with record cleared.
- REPORT: stage_sel=NUM_LEVELS+2, bgm 0; finish → TITLE.
- CREDITS: stage_sel=NUM_LEVELS+3; restart or esc → TITLE.
- The pause edge detector updates on every tick, including ticks outside PLAY. A held pause_req therefore never re-toggles.
- An async reset asserted mid-frame takes effect immediately; there is no tick dependency.

Decomposition:
- Package game_flow_pkg holds:
  - the flow state enum;
  - stage_sel offset constants (SEL_DEAD_OFS=1, SEL_REPORT_OFS=2, SEL_CREDITS_OFS=3, SEL_PAUSE_OFS=4);
  - a function computing SEL_W.
- One sub-module, tick_edge: a frame-tick-qualified rising-edge detector, used for pause_req.

Test Plan:
- Reset_n low mid-frame → stage_sel 0, lvl_reset 2'b11, lives 3 immediately. Release, then 2 ticks idle → outputs unchanged.
- confirm, selected=1 → LOAD for 1 tick, then PLAY with lvl_reset 2'b10, bgm 1. level_done → LOAD then PLAY cur=2 with lvl_reset 2'b01. level_done → stage_sel 4 (report). finish → 0.
- In level 2: saved, then death → record 2, stage_sel 3, lives 2, deaths 1. restart → PLAY level 2. Two more deaths → OVER with lives 0. restart → title with record 0.
- death and level_done on the same tick in level 1 → DEAD taken, cur stays 1.
- pause_req held high for 5 ticks in PLAY → one PAUSE entry, frame_en 0, stage_sel 6. death during pause is ignored. Release, then high again → PLAY, frame_en 1.
- From title with record 0: confirm selected=2 → ignored, stays title. selected=3 → credits, stage_sel 5. Drive 255+ deaths → deaths saturates at 8'hFF.
